// File: rtl/serial_subtract_ctrl_if.sv
// Operand/result and cell-side signals of the bit-serial subtract sequencer.
// The slave modport is the sequencer; the master is whoever feeds it and hosts the cell.
interface serial_subtract_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cell_a;
    logic             cell_b;
    logic             cell_bin;
    logic             cell_d;
    logic             cell_bout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport slave (
        input  start, a_in, b_in, cell_d, cell_bout,
        output cell_a, cell_b, cell_bin, busy, done, diff, borrow_out
    );

    modport master (
        output start, a_in, b_in, cell_d, cell_bout,
        input  cell_a, cell_b, cell_bin, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial sequencer around an external full-subtractor cell: feeds operands LSB first,
// recirculates the borrow and assembles the WIDTH-bit difference.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    serial_subtract_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_w_sh;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_w_next;
    logic             w_last;
    logic             w_accept;

    assign w_w_next = (r_w_sh >> 1) | (WIDTH'(bus.cell_d) << (WIDTH - 1));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);

    // Operand shifters shift in zeros and the borrow is cleared on the last bit,
    // so every cell input is a flop that already reads 0 outside SHIFT.
    assign bus.cell_a     = r_a_sh[0];
    assign bus.cell_b     = r_b_sh[0];
    assign bus.cell_bin   = r_borrow;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_bout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_w_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_w_sh <= w_w_next;
                    if (w_last) begin
                        r_diff   <= w_w_next;
                        r_bout   <= bus.cell_bout;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_borrow <= bus.cell_bout;
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_a_sh   <= bus.a_in;
                        r_b_sh   <= bus.b_in;
                        r_w_sh   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
Bit-serial sequencer that drives the single-bit full-subtractor cell (s = a^b^bin, borrow-out = ~a&b | ~(a^b)&bin).
- Upstream role: accepts WIDTH-bit operands and feeds the cell one bit pair per cycle, LSB first.
- Downstream role: consumes the cell's difference and borrow-out, recirculates the borrow as the next borrow-in, and assembles the WIDTH-bit result.
- Gives the fault-simulation flow a sequential circuit around the subtractor cell, for pattern generation across multiple cycles.

Parameters:
WIDTH, 8, operand/result width in bits (legal 1..32).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
cell_a  output  1  bit of minuend presented to cell
cell_b  output  1  bit of subtrahend presented to cell
cell_bin  output  1  borrow-in presented to cell
cell_d  input  1  cell difference bit (combinational from cell_a/b/bin)
cell_bout  input  1  cell borrow-out (combinational)
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  registered difference, a_in - b_in mod 2^WIDTH
borrow_out  output  1  final borrow; 1 iff a_in < b_in (unsigned)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, borrow_out=0, cell_a/b/bin=0; internal shift registers, borrow register and bit counter cleared. Reset mid-SHIFT aborts the operation; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: cell_a/b/bin driven 0. start=1 at edge → latch a_in/b_in into shift regs a_sh/b_sh, borrow_reg=0, cnt=0, go to SHIFT.
- SHIFT: cell_a=a_sh[0], cell_b=b_sh[0], cell_bin=borrow_reg (all from registers, glitch-free). Each edge:
  - shift cell_d into the MSB of work reg w_sh (right shift);
  - a_sh/b_sh shift right;
  - borrow_reg<=cell_bout;
  - cnt++.
  - On the edge where cnt==WIDTH-1: diff<=final w_sh (including this bit), borrow_out<=cell_bout, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. diff/borrow_out hold until the next completed operation, not cleared by start. start=1 in DONE is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: start accepted at edge k → busy high from k through k+WIDTH; done high for the cycle after edge k+WIDTH. Throughput: one result per WIDTH+1 cycles.
- start while busy: ignored; operands not re-latched; result unaffected.
- a_in/b_in changes after acceptance: no effect.
- Arithmetic: pure unsigned modular subtraction; no saturation. borrow_out is the only overflow indication.
- WIDTH=1: SHIFT lasts one cycle; the behaviour is otherwise identical.
- cell_d/cell_bout are sampled only in SHIFT; their values in other states are don't-care.

Test Plan:
- Bench cell is a behavioural full subtractor. WIDTH=8, a=100, b=37, start pulse → busy 8 cycles; done pulse on the 9th cycle after acceptance; diff=63, borrow_out=0.
- WIDTH=8, a=5, b=9 → diff=8'hFC, borrow_out=1. Then a=0, b=255 → diff=8'h01, borrow_out=1. Then a=b=8'hAA → diff=0, borrow_out=0.
- Back-to-back: hold start=1 with a=200, b=1, then change to a=3, b=4 during SHIFT. First done gives diff=199, borrow 0 (mid-op changes ignored). start still high in DONE gives second result diff=8'hFF, borrow 1 exactly 9 cycles later.
- Reset mid-op: assert rst asynchronously at cycle 4 of SHIFT → all outputs 0 immediately, state IDLE, no done pulse. After release, a=10, b=3 → diff=7.
- Exhaustive WIDTH=1 and WIDTH=4 (all a,b pairs) against a reference model; also check cell_bin sequence equals the expected borrow chain per bit.
- Stuck-at sanity: force cell_bout stuck-at-0 → a=0, b=1 (WIDTH=4) yields diff=4'h1, borrow_out=0, detectable versus the fault-free diff=4'hF, borrow_out=1.
